// File: rtl/wb_sram_arbiter_if.sv
// wb_sram_arbiter_if
// Purpose : one Wishbone master's connection to the shared-SRAM arbiter.
// Signals : cyc, stb, we, sel[3:0], adr[31:0], dat_w[31:0] come from the master;
//           dat_r[31:0] and ack go back to the master.
// Modports: master (drives the request side), slave (the arbiter side).
interface wb_sram_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_sram_arbiter.sv
// wb_sram_arbiter
// Purpose : shares one 32-bit asynchronous SRAM (two 16-bit chips, common address
//           and ce/oe/we strobes, per-byte enables) between two Wishbone masters.
//           Round-robin arbitration, then one SRAM read or write per grant with a
//           programmable number of wait states. Every SRAM pin is registered.
// Ports   : i_clk        system clock
//           i_reset_n    synchronous reset, active-low
//           io_m0/io_m1  Wishbone slave ports (cyc/stb/we/sel/adr/dat_w in, dat_r/ack out)
//           o_sram_adr   SRAM word address (byte address bits [adr_width+1:2])
//           io_sram_dat  SRAM data, driven only around a write, otherwise high-Z
//           o_sram_be_n  byte enables, active-low
//           o_sram_ce_n / o_sram_oe_n / o_sram_we_n  SRAM strobes, active-low
module wb_sram_arbiter #(
    parameter int adr_width   = 18,
    parameter int wait_states = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    wb_sram_arbiter_if.slave     io_m0,
    wb_sram_arbiter_if.slave     io_m1,
    output logic [adr_width-1:0] o_sram_adr,
    inout  wire  [31:0]          io_sram_dat,
    output logic [3:0]           o_sram_be_n,
    output logic                 o_sram_ce_n,
    output logic                 o_sram_oe_n,
    output logic                 o_sram_we_n
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // A wait-state count of 0 is treated as 1.
    localparam int         WS_EFF   = (wait_states < 1) ? 1 : wait_states;
    localparam logic [3:0] CNT_INIT = 4'(WS_EFF - 1);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_last_grant;   // 0 = m0, 1 = m1; also selects the master to ack
    logic [adr_width-1:0]  r_adr;
    logic [3:0]            r_be_n;
    logic                  r_ce_n;
    logic                  r_oe_n;
    logic                  r_we_n;
    logic [31:0]           r_dat_w;
    logic                  r_dat_oe;
    logic [31:0]           r_dat_r;
    logic                  r_ack0;
    logic                  r_ack1;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_pick_m1;
    logic                  w_we;
    logic [3:0]            w_sel;
    logic [31:0]           w_adr;
    logic [31:0]           w_dat_w;
    logic                  w_unused_adr;

    assign w_req0 = io_m0.cyc & io_m0.stb;
    assign w_req1 = io_m1.cyc & io_m1.stb;

    // Round-robin choice: on a tie the master that did not win last time gets the bus.
    always_comb begin
        w_pick_m1 = 1'b0;
        if (w_req0 && w_req1) begin
            w_pick_m1 = ~r_last_grant;
        end else if (w_req1) begin
            w_pick_m1 = 1'b1;
        end else begin
            w_pick_m1 = 1'b0;
        end
    end

    // Route the chosen master's request fields to the sequencer.
    always_comb begin
        w_we    = io_m0.we;
        w_sel   = io_m0.sel;
        w_adr   = io_m0.adr;
        w_dat_w = io_m0.dat_w;
        if (w_pick_m1) begin
            w_we    = io_m1.we;
            w_sel   = io_m1.sel;
            w_adr   = io_m1.adr;
            w_dat_w = io_m1.dat_w;
        end else begin
            w_we    = io_m0.we;
            w_sel   = io_m0.sel;
            w_adr   = io_m0.adr;
            w_dat_w = io_m0.dat_w;
        end
    end

    // Byte-lane bits and bits above the SRAM word range carry no meaning here.
    assign w_unused_adr = ^{w_adr[31:adr_width+2], w_adr[1:0]};

    // Arbitration and access sequencer; SRAM pins, read data and acks are all registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_adr        <= {adr_width{1'b0}};
            r_be_n       <= 4'hF;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_dat_w      <= 32'd0;
            r_dat_oe     <= 1'b0;
            r_dat_r      <= 32'd0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_last_grant <= w_pick_m1;
                        r_adr        <= w_adr[adr_width+1:2];
                        r_be_n       <= ~w_sel;
                        r_ce_n       <= 1'b0;
                        r_cnt        <= CNT_INIT;
                        if (w_we) begin
                            r_we_n   <= 1'b0;
                            r_dat_w  <= w_dat_w;
                            r_dat_oe <= 1'b1;
                            r_state  <= ST_WRITE;
                        end else begin
                            r_oe_n   <= 1'b0;
                            r_state  <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (r_cnt == 4'd0) begin
                        r_dat_r <= io_sram_dat;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_be_n  <= 4'hF;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                ST_WRITE: begin
                    // Data stays driven one more cycle after we_n rises for hold time.
                    if (r_cnt == 4'd0) begin
                        r_we_n  <= 1'b1;
                        r_ce_n  <= 1'b1;
                        r_be_n  <= 4'hF;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    // A master that dropped its cycle mid-access gets no ack.
                    if (r_last_grant) begin
                        r_ack1 <= w_req1;
                    end else begin
                        r_ack0 <= w_req0;
                    end
                    r_dat_oe <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_sram_dat = r_dat_oe ? r_dat_w : {32{1'bz}};
    assign o_sram_adr  = r_adr;
    assign o_sram_be_n = r_be_n;
    assign o_sram_ce_n = r_ce_n;
    assign o_sram_oe_n = r_oe_n;
    assign o_sram_we_n = r_we_n;
    assign io_m0.dat_r = r_dat_r;
    assign io_m1.dat_r = r_dat_r;
    assign io_m0.ack   = r_ack0;
    assign io_m1.ack   = r_ack1;

endmodule
